// File: rtl/cv32e40px_apu_core_pkg.sv
// +----------------------------------------------------------------------+
// | cv32e40px_apu_core_pkg                                               |
// | APU width constants shared by the dispatcher, its tag FIFO and bus.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package cv32e40px_apu_core_pkg;
  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;
  localparam int APU_DISP_DEPTH   = 4;
endpackage

`default_nettype wire

// File: rtl/cv32e40px_apu_disp_if.sv
// +----------------------------------------------------------------------+
// | cv32e40px_apu_disp_if                                                |
// | Request/response bus between the dispatcher (master) and the APU.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface cv32e40px_apu_disp_if;
  import cv32e40px_apu_core_pkg::*;

  logic                                apu_req;
  logic                                apu_gnt;
  logic [APU_NARGS_CPU-1:0][31:0]      apu_operands;
  logic [APU_WOP_CPU-1:0]              apu_op;
  logic [APU_NDSFLAGS_CPU-1:0]         apu_flags;
  logic                                apu_rvalid;
  logic [31:0]                         apu_rdata;
  logic [APU_NUSFLAGS_CPU-1:0]         apu_rflags;

  modport master (
    output apu_req, apu_operands, apu_op, apu_flags,
    input  apu_gnt, apu_rvalid, apu_rdata, apu_rflags
  );

  modport slave (
    input  apu_req, apu_operands, apu_op, apu_flags,
    output apu_gnt, apu_rvalid, apu_rdata, apu_rflags
  );
endinterface

`default_nettype wire

// File: rtl/cv32e40px_apu_tag_fifo.sv
// +----------------------------------------------------------------------+
// | cv32e40px_apu_tag_fifo                                               |
// | In-order destination-tag FIFO with per-entry source-register match. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module cv32e40px_apu_tag_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [ADDR_W-1:0]      waddr_i,
  input  logic [2:0][ADDR_W-1:0] rs_addr_i,
  output logic [ADDR_W-1:0]      head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [CNT_W-1:0]       count_o,
  output logic [DEPTH-1:0]       match_o
);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= waddr_i;
  end

  // An entry is live when its distance from the read pointer is below count
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [PTR_W-1:0] w_off;
    logic             w_hit;
    assign w_off = PTR_W'(i) - r_rd_ptr;
    assign w_hit = ((rs_addr_i[0] != '0) && (rs_addr_i[0] == r_mem[i])) ||
                   ((rs_addr_i[1] != '0) && (rs_addr_i[1] == r_mem[i])) ||
                   ((rs_addr_i[2] != '0) && (rs_addr_i[2] == r_mem[i]));
    assign match_o[i] = ({1'b0, w_off} < r_count) && w_hit;
  end

endmodule

`default_nettype wire

// File: rtl/cv32e40px_apu_disp.sv
// +----------------------------------------------------------------------+
// | cv32e40px_apu_disp                                                   |
// | APU dispatcher: issue, in-order tag tracking, registered writeback. |
// | Optional sticky orphan-response error: CV32E40PX_APU_DISP_ERR_EN.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module cv32e40px_apu_disp
  import cv32e40px_apu_core_pkg::*;
#(
  parameter int DEPTH  = APU_DISP_DEPTH,
  parameter int ADDR_W = 6,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           enable_i,
  output logic                           ready_o,
  input  logic [APU_NARGS_CPU-1:0][31:0] operands_i,
  input  logic [APU_WOP_CPU-1:0]         op_i,
  input  logic [APU_NDSFLAGS_CPU-1:0]    flags_i,
  input  logic [ADDR_W-1:0]              waddr_i,
  cv32e40px_apu_disp_if.master           apu,
  output logic                           wb_valid_o,
  output logic [ADDR_W-1:0]              wb_waddr_o,
  output logic [31:0]                    wb_data_o,
  output logic [APU_NUSFLAGS_CPU-1:0]    wb_flags_o,
  input  logic [2:0][ADDR_W-1:0]         rs_addr_i,
  output logic                           dep_o,
  output logic                           busy_o,
  output logic                           err_o
);

  logic [ADDR_W-1:0]             w_head;
  logic                          w_full;
  logic                          w_empty;
  logic [CNT_W-1:0]              w_count;
  logic [DEPTH-1:0]              w_match;
  logic                          w_pop;
  logic                          w_wb_hit;
  logic                          r_wb_valid;
  logic [ADDR_W-1:0]             r_wb_waddr;
  logic [31:0]                   r_wb_data;
  logic [APU_NUSFLAGS_CPU-1:0]   r_wb_flags;

  // Full blocks issue even when a pop lands in the same cycle
  assign apu.apu_req      = enable_i & ~w_full;
  assign apu.apu_operands = operands_i;
  assign apu.apu_op       = op_i;
  assign apu.apu_flags    = flags_i;
  assign ready_o          = apu.apu_req & apu.apu_gnt;
  assign w_pop            = apu.apu_rvalid & ~w_empty;

  cv32e40px_apu_tag_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_tag_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (ready_o),
    .pop_i     (w_pop),
    .waddr_i   (waddr_i),
    .rs_addr_i (rs_addr_i),
    .head_o    (w_head),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .count_o   (w_count),
    .match_o   (w_match)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_valid <= 1'b0;
      r_wb_waddr <= '0;
      r_wb_data  <= '0;
      r_wb_flags <= '0;
    end else begin
      r_wb_valid <= w_pop;
      if (w_pop) begin
        r_wb_waddr <= w_head;
        r_wb_data  <= apu.apu_rdata;
        r_wb_flags <= apu.apu_rflags;
      end
    end
  end

  assign wb_valid_o = r_wb_valid;
  assign wb_waddr_o = r_wb_waddr;
  assign wb_data_o  = r_wb_data;
  assign wb_flags_o = r_wb_flags;

  assign w_wb_hit = r_wb_valid &&
                    (((rs_addr_i[0] != '0) && (rs_addr_i[0] == r_wb_waddr)) ||
                     ((rs_addr_i[1] != '0) && (rs_addr_i[1] == r_wb_waddr)) ||
                     ((rs_addr_i[2] != '0) && (rs_addr_i[2] == r_wb_waddr)));
  assign dep_o    = (|w_match) | w_wb_hit;
  assign busy_o   = (w_count != '0) | r_wb_valid;

`ifdef CV32E40PX_APU_DISP_ERR_EN
  logic r_err;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       r_err <= 1'b0;
    else if (apu.apu_rvalid && w_empty) r_err <= 1'b1;
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/cv32e40px_apu_disp.md
CV32E40PX_APU_DISP -- requirements
Module: cv32e40px_apu_disp

Interface
REQ-001 SHALL have parameter DEPTH, default 4, max outstanding APU requests (power of 2, 2..8).
REQ-002 SHALL have parameter ADDR_W, default 6, writeback register address width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk_i  input  1  clock (all state on rising edge).
REQ-004 SHALL have rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have enable_i  input  1  core requests an APU op this cycle.
REQ-006 SHALL have ready_o  output  1  op accepted (request handshake completed).
REQ-007 SHALL have operands_i  input  APU_NARGS_CPU x 32  source operands.
REQ-008 SHALL have op_i  input  APU_WOP_CPU  op code; flags_i  input  APU_NDSFLAGS_CPU  format/rounding flags.
REQ-009 SHALL have waddr_i  input  ADDR_W  destination register of the op.
REQ-010 SHALL have apu_req_o  output  1; apu_gnt_i  input  1 (APU request handshake).
REQ-011 SHALL have apu_operands_o / apu_op_o / apu_flags_o  outputs  same widths as REQ-007/008.
REQ-012 SHALL have apu_rvalid_i  input  1; apu_rdata_i  input  32; apu_rflags_i  input  APU_NUSFLAGS_CPU (response, no backpressure).
REQ-013 SHALL have wb_valid_o  output  1; wb_waddr_o  output  ADDR_W; wb_data_o  output  32; wb_flags_o  output  APU_NUSFLAGS_CPU.
REQ-014 SHALL have rs_addr_i  input  3 x ADDR_W  source registers of the next op; dep_o  output  1  hazard.
REQ-015 SHALL have busy_o  output  1; err_o  output  1.

Function
REQ-016 apu_req_o SHALL equal enable_i AND (count < DEPTH), combinational; payload outputs SHALL pass operands_i/op_i/flags_i through unregistered.
REQ-017 ready_o SHALL equal apu_req_o AND apu_gnt_i; upstream holds enable_i and payload stable until ready_o.
REQ-018 On ready_o, waddr_i SHALL be pushed into an in-order tag FIFO and count incremented.
REQ-019 Responses are in order; on apu_rvalid_i with count>0 the FIFO head SHALL be popped and count decremented.
REQ-020 Writeback SHALL be registered: one cycle after apu_rvalid_i, wb_valid_o=1 for exactly one cycle with head waddr, apu_rdata_i, apu_rflags_i.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-022 Full (count==DEPTH): apu_req_o SHALL be 0 even if a pop occurs the same cycle (issue resumes next cycle).
REQ-023 apu_rvalid_i with count==0 SHALL be ignored: no pop, no writeback, count stays 0.
REQ-024 dep_o SHALL be 1 when any non-zero rs_addr_i matches any valid FIFO entry or the wb register while wb_valid_o=1; address 0 never matches.
REQ-025 busy_o SHALL be 1 when count>0 or wb_valid_o=1.
REQ-026 Back-to-back grants SHALL be sustainable at one op per cycle while not full.

Reset
REQ-027 Reset SHALL clear count, pointers, wb register, err flag; wb_valid_o, busy_o, err_o, dep_o read 0; apu_req_o follows REQ-016 (count=0).
REQ-028 Reset mid-operation SHALL discard all outstanding tags; later responses fall under REQ-023.

Configuration
REQ-029 With macro CV32E40PX_APU_DISP_ERR_EN defined, err_o SHALL be a sticky flag set by a response with count==0, cleared only by reset.
REQ-030 Without CV32E40PX_APU_DISP_ERR_EN, err_o SHALL be constant 0 and no error register SHALL exist.

Structure
REQ-031 APU width constants SHALL come from cv32e40px_apu_core_pkg; a new constant APU_DISP_DEPTH (default 4) SHALL be added there.
REQ-032 The tag FIFO SHALL be sub-module cv32e40px_apu_tag_fifo (push/pop/full/empty/count, entry-match vector).

Verification
REQ-033 Single op waddr=5, gnt same cycle, rvalid 3 cycles later data=0x3F800000 -> wb_valid_o one cycle after, wb_waddr_o=5, wb_data_o=0x3F800000.
REQ-034 Four ops waddr 1..4, gnt each cycle, no response -> fifth enable_i sees apu_req_o=0; rvalid pops 1, req reasserts next cycle.
REQ-035 Full + rvalid same cycle -> no grant that cycle, count 4->3, issue next cycle.
REQ-036 Outstanding waddr=7, rs_addr_i={0,7,2} -> dep_o=1; after wb of 7 completes -> dep_o=0; rs={0,0,0} -> dep_o=0.
REQ-037 rvalid with count=0 -> no wb_valid_o; err_o=1 with macro, 0 without.
REQ-038 Reset asserted with 2 outstanding -> count 0, busy_o=0, subsequent rvalid produces no writeback.
